// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU's instruction-fetch (I)
// side and its data-access (D) side.
//
// A winning request is latched into the mem_* registers at grant and held
// stable until mem_rdy, then rdy/data are returned to the owner for one cycle.
// Every transaction is followed by one IDLE cycle in which new requests are
// sampled.
//
// Parameters
//   PRIO_MODE : 0 = round-robin between I and D, 1 = D always wins contention
//   TIMEOUT   : busy cycles without mem_rdy before abort (0 = never)
//
// Ports
//   clock, reset                      : clock, synchronous active-high reset
//   icache_addr/req -> data/rdy       : fetch side
//   dcache_addr/wdata/ws/req/wr       : data side request
//   dcache_rdata/rdy                  : data side response
//   mem_addr/wdata/ws/req/wr          : registered memory request
//   mem_rdata/rdy                     : memory response
//   grant_d                           : D side currently owns the port
//   timeout_err                       : sticky, set on any timeout abort
module mem_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] icache_addr,
  input  logic        icache_req,
  output logic [31:0] icache_data,
  output logic        icache_rdy,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  input  logic [1:0]  dcache_ws,
  input  logic        dcache_req,
  input  logic        dcache_wr,
  output logic [31:0] dcache_rdata,
  output logic        dcache_rdy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_ws,
  output logic        mem_req,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdy,
  output logic        grant_d,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  // Counter value at which the owner is aborted; unused when TIMEOUT == 0.
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        last_d;     // last grant went to D
  logic [15:0] tmo_cnt;
  logic        busy, tmo_hit, done;
  logic        win_i, win_d;

  assign busy    = (state != IDLE);
  // mem_rdy in the limit cycle wins, so the abort requires mem_rdy == 0.
  assign tmo_hit = (TIMEOUT > 0) && busy && !mem_rdy && (tmo_cnt == TMO_LIM);
  assign done    = busy && (mem_rdy || tmo_hit);

  always_comb begin
    state_nxt = state;
    win_i     = 1'b0;
    win_d     = 1'b0;
    case (state)
      IDLE: begin
        if (icache_req && dcache_req) begin
          win_d = (PRIO_MODE == 1) ? 1'b1 : !last_d;
          win_i = !win_d;
        end else begin
          win_i = icache_req;
          win_d = dcache_req;
        end
        if (win_d)      state_nxt = BUSY_D;
        else if (win_i) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_ws      <= '0;
      mem_wr      <= 1'b0;
      mem_req     <= 1'b0;
      grant_d     <= 1'b0;
      timeout_err <= 1'b0;
      last_d      <= 1'b1;   // first contention goes to I
      tmo_cnt     <= '0;
    end else if (win_i || win_d) begin
      mem_addr  <= win_d ? dcache_addr  : icache_addr;
      mem_wdata <= win_d ? dcache_wdata : 32'h0;
      mem_ws    <= win_d ? dcache_ws    : 2'b00;
      mem_wr    <= win_d && dcache_wr;
      mem_req   <= 1'b1;
      grant_d   <= win_d;
      last_d    <= win_d;
      tmo_cnt   <= '0;
    end else if (done) begin
      mem_req <= 1'b0;
      grant_d <= 1'b0;
      if (tmo_hit) timeout_err <= 1'b1;
    end else if (busy && tmo_cnt != 16'hFFFF) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Response path is a pass-through of memory data, zeroed on timeout abort.
  assign icache_rdy   = (state == BUSY_I) && (mem_rdy || tmo_hit);
  assign dcache_rdy   = (state == BUSY_D) && (mem_rdy || tmo_hit);
  assign icache_data  = tmo_hit ? 32'h0 : mem_rdata;
  assign dcache_rdata = tmo_hit ? 32'h0 : mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: u_rr (round-robin, TIMEOUT=8) carries the scoreboarded
// tests; u_fp (fixed D priority) checks priority behaviour directly.
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // round-robin instance
  logic [31:0] icache_addr = '0, dcache_addr = '0, dcache_wdata = '0;
  logic        icache_req = 0, dcache_req = 0, dcache_wr = 0;
  logic [1:0]  dcache_ws = '0;
  logic [31:0] icache_data, dcache_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        icache_rdy, dcache_rdy, mem_req, mem_wr, grant_d, timeout_err;
  logic [1:0]  mem_ws;
  logic        mem_rdy = 0, data_sel = 0;
  logic [31:0] rdata_val = '0;
  assign mem_rdata = data_sel ? rdata_val : (mem_addr ^ 32'h5A5A_0000);

  // fixed-priority instance
  logic        p_icache_req = 0, p_dcache_req = 0, p_mem_rdy = 0;
  logic [31:0] p_icache_data, p_dcache_rdata, p_mem_addr, p_mem_wdata;
  logic        p_icache_rdy, p_dcache_rdy, p_mem_req, p_mem_wr, p_grant_d, p_timeout_err;
  logic [1:0]  p_mem_ws;
  logic [31:0] p_mem_rdata = 32'h0BAD_F00D;

  mem_arbiter #(.PRIO_MODE(0), .TIMEOUT(8)) u_rr (
    .clock(clock), .reset(reset),
    .icache_addr(icache_addr), .icache_req(icache_req),
    .icache_data(icache_data), .icache_rdy(icache_rdy),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata), .dcache_ws(dcache_ws),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr),
    .dcache_rdata(dcache_rdata), .dcache_rdy(dcache_rdy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ws(mem_ws),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .grant_d(grant_d), .timeout_err(timeout_err));

  mem_arbiter #(.PRIO_MODE(1), .TIMEOUT(0)) u_fp (
    .clock(clock), .reset(reset),
    .icache_addr(32'h0000_0040), .icache_req(p_icache_req),
    .icache_data(p_icache_data), .icache_rdy(p_icache_rdy),
    .dcache_addr(32'h0000_0080), .dcache_wdata(32'h0), .dcache_ws(2'b00),
    .dcache_req(p_dcache_req), .dcache_wr(1'b0),
    .dcache_rdata(p_dcache_rdata), .dcache_rdy(p_dcache_rdy),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_ws(p_mem_ws),
    .mem_req(p_mem_req), .mem_wr(p_mem_wr), .mem_rdata(p_mem_rdata), .mem_rdy(p_mem_rdy),
    .grant_d(p_grant_d), .timeout_err(p_timeout_err));

  int passes = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  typedef struct { logic is_d; logic [31:0] data; } exp_t;
  exp_t q[$];

  task automatic push(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d; e.data = data;
    q.push_back(e);
  endtask

  // response monitor: every rdy pulse must match the next expected transaction
  always @(negedge clock) begin
    if (icache_rdy || dcache_rdy) begin
      if (q.size() == 0) chk("spurious_rdy", 32'(icache_rdy | dcache_rdy), 32'h0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_both_rdy", 32'(icache_rdy & dcache_rdy), 32'h0);
        chk("sb_side", 32'(dcache_rdy), 32'(e.is_d));
        chk("sb_data", e.is_d ? dcache_rdata : icache_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_grant_d", 32'(grant_d), 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    chk("rst_p_mem_req", 32'(p_mem_req), 0);
    reset = 0;
    tick();

    // I-only read, mem_rdy in 2nd busy cycle
    icache_req = 1; icache_addr = 32'h100;
    push(0, 32'hDEAD_BEEF);
    tick();
    icache_req = 0;
    chk("i_mem_req", 32'(mem_req), 1);
    chk("i_mem_addr", mem_addr, 32'h100);
    chk("i_mem_wr", 32'(mem_wr), 0);
    chk("i_rdy_early", 32'(icache_rdy), 0);
    tick();
    mem_rdy = 1; data_sel = 1; rdata_val = 32'hDEAD_BEEF; #1;
    chk("i_rdy", 32'(icache_rdy), 1);
    chk("i_data", icache_data, 32'hDEAD_BEEF);
    chk("i_d_rdy", 32'(dcache_rdy), 0);
    tick();
    mem_rdy = 0;
    chk("i_idle_req", 32'(mem_req), 0);

    // D write, mem_rdy in 3rd busy cycle
    dcache_req = 1; dcache_wr = 1; dcache_addr = 32'h2000;
    dcache_wdata = 32'h1234_5678; dcache_ws = 2'd2;
    push(1, 32'hCAFE_F00D);
    tick();
    dcache_req = 0; dcache_wr = 0; dcache_wdata = '0; dcache_ws = '0; dcache_addr = '0;
    for (int b = 0; b < 2; b++) begin
      chk("d_mem_addr", mem_addr, 32'h2000);
      chk("d_mem_wdata", mem_wdata, 32'h1234_5678);
      chk("d_mem_ws", 32'(mem_ws), 2);
      chk("d_mem_wr", 32'(mem_wr), 1);
      chk("d_grant", 32'(grant_d), 1);
      tick();
    end
    mem_rdy = 1; rdata_val = 32'hCAFE_F00D; #1;
    chk("d_rdy", 32'(dcache_rdy), 1);
    tick();
    mem_rdy = 0; data_sel = 0;
    chk("d_idle_req", 32'(mem_req), 0);
    chk("d_idle_grant", 32'(grant_d), 0);

    // round-robin contention, mem_rdy held high (also high in IDLE cycles)
    icache_addr = 32'h10; dcache_addr = 32'h20;
    icache_req = 1; dcache_req = 1; mem_rdy = 1;
    for (int k = 0; k < 4; k++)
      push(k[0], ((k % 2) ? 32'h20 : 32'h10) ^ 32'h5A5A_0000);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_mem_req", 32'(mem_req), 1);
      chk("rr_grant", 32'(grant_d), 32'(k % 2));
      chk("rr_addr", mem_addr, (k % 2) ? 32'h20 : 32'h10);
      tick();
      chk("rr_idle", 32'(mem_req), 0);
    end
    icache_req = 0; dcache_req = 0; mem_rdy = 0;
    tick();
    chk("rr_end_idle", 32'(mem_req), 0);

    // fixed priority on u_fp
    p_icache_req = 1; p_dcache_req = 1; p_mem_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fp_grant_d", 32'(p_grant_d), 1);
      chk("fp_d_rdy", 32'(p_dcache_rdy), 1);
      chk("fp_i_rdy", 32'(p_icache_rdy), 0);
      tick();
    end
    p_dcache_req = 0;
    tick();
    p_icache_req = 0;
    chk("fp_i_grant", 32'(p_grant_d), 0);
    chk("fp_i_req", 32'(p_mem_req), 1);
    chk("fp_i_addr", p_mem_addr, 32'h40);
    chk("fp_i_rdy2", 32'(p_icache_rdy), 1);
    chk("fp_i_data", p_icache_data, 32'h0BAD_F00D);
    tick();
    p_mem_rdy = 0;
    chk("fp_idle", 32'(p_mem_req), 0);

    // timeout limit cycle with mem_rdy: normal completion
    dcache_req = 1; dcache_addr = 32'h3004;
    push(1, 32'h3004 ^ 32'h5A5A_0000);
    tick();
    dcache_req = 0;
    for (int b = 1; b < 8; b++) tick();
    mem_rdy = 1; #1;
    chk("t8_rdy", 32'(dcache_rdy), 1);
    tick();
    mem_rdy = 0;
    chk("t8_no_err", 32'(timeout_err), 0);
    chk("t8_idle", 32'(mem_req), 0);

    // timeout abort
    dcache_req = 1; dcache_addr = 32'h3000;
    push(1, 32'h0);
    tick();
    dcache_req = 0;
    for (int b = 1; b < 8; b++) begin
      chk("to_wait_rdy", 32'(dcache_rdy), 0);
      tick();
    end
    chk("to_rdy", 32'(dcache_rdy), 1);
    chk("to_data", dcache_rdata, 32'h0);
    tick();
    chk("to_err", 32'(timeout_err), 1);
    chk("to_idle", 32'(mem_req), 0);
    tick(); tick();
    chk("to_err_sticky", 32'(timeout_err), 1);

    // reset in the 2nd busy cycle of an I read
    icache_req = 1; icache_addr = 32'h400;
    tick();
    icache_req = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("mr_mem_req", 32'(mem_req), 0);
    chk("mr_mem_addr", mem_addr, 0);
    chk("mr_tmo_clr", 32'(timeout_err), 0);
    mem_rdy = 1; #1;
    chk("mr_no_rdy", 32'(icache_rdy), 0);
    tick();
    mem_rdy = 0;
    chk("mr_still_idle", 32'(mem_req), 0);
    tick();

    chk("sb_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory port between the CPU's instruction-fetch side and its data-access side.
- Sits between the cpu block's icache_* / dcache_* ports and the single memory/bus interface.
- Latches the winning request and holds it stable on the memory side until mem_rdy, then returns data and rdy to the owner.
- Provides round-robin or fixed data-priority arbitration, plus an optional hang timeout.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between I and D; 1 = D side always wins contention.
- TIMEOUT, 0, cycles in a busy state without mem_rdy before abort; 0 disables the timeout. Range 0..65535.

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- icache_addr  input  32  fetch address; sampled at grant
- icache_req  input  1  fetch request, level
- icache_data  output  32  fetch data; valid only when icache_rdy=1
- icache_rdy  output  1  one-cycle completion pulse for the I side
- dcache_addr  input  32  data address; sampled at grant
- dcache_wdata  input  32  store data; sampled at grant
- dcache_ws  input  2  store size; sampled at grant
- dcache_req  input  1  data request, level
- dcache_wr  input  1  1 = write, 0 = read; sampled at grant
- dcache_rdata  output  32  load data; valid only when dcache_rdy=1
- dcache_rdy  output  1  one-cycle completion pulse for the D side
- mem_addr  output  32  registered address of the granted request
- mem_wdata  output  32  registered write data
- mem_ws  output  2  registered write size
- mem_req  output  1  registered; high throughout a busy state
- mem_wr  output  1  registered write flag; forced 0 for I-side grants
- mem_rdata  input  32  memory read data
- mem_rdy  input  1  memory completion, one-cycle pulse
- grant_d  output  1  1 while the D side owns the port
- timeout_err  output  1  sticky; set on any timeout abort

Behaviour:
- States: IDLE, BUSY_I, BUSY_D.
- Reset values: state=IDLE; mem_req, mem_wr, grant_d, timeout_err = 0; mem_addr, mem_wdata, mem_ws = 0; last_grant = D (so the first contention goes to I in round-robin mode); timeout counter = 0.
- IDLE transitions:
  - only icache_req -> BUSY_I.
  - only dcache_req -> BUSY_D.
  - both requests, PRIO_MODE=1 -> BUSY_D.
  - both requests, PRIO_MODE=0 -> the side opposite last_grant.
  - neither -> stay in IDLE.
- On grant:
  - Latch the winner's addr, wdata, ws and wr into the mem_* registers. For an I grant, latch wr=0, wdata=0, ws=0.
  - Set mem_req=1 and update last_grant.
  - The mem_* outputs stay constant for the whole busy state.
- Completion in BUSY_x with mem_rdy=1:
  - x_rdy=1 combinationally in that cycle, and x_data = mem_rdata (pass-through).
  - Next state is IDLE and mem_req=0.
- Outputs outside completion:
  - icache_rdy = (state==BUSY_I) & mem_rdy; dcache_rdy = (state==BUSY_D) & mem_rdy.
  - The other side's rdy is never asserted.
  - icache_data and dcache_rdata always drive mem_rdata.
- Latency and throughput:
  - Request sampled in cycle N; mem_req is high from cycle N+1.
  - Minimum completion is in cycle N+1 (mem_rdy in the first busy cycle).
  - A mandatory IDLE cycle follows each transaction. A requester may keep req high after rdy to issue its next request, which is sampled in that IDLE cycle.
  - Back-to-back throughput is therefore one transaction per 2 cycles at best.
- Contention: a request not granted stays pending and is considered at the next IDLE. The loser's inputs are ignored until it is granted.
- mem_rdy while in IDLE is ignored: no rdy pulse and no state change.
- Timeout (TIMEOUT>0):
  - A 16-bit counter clears on grant and increments each busy cycle without mem_rdy.
  - When the counter reaches TIMEOUT-1 and mem_rdy=0 in that cycle: pulse the owner's rdy with data forced to 0, set timeout_err, and go to IDLE with mem_req=0.
  - mem_rdy in the same cycle as the limit wins: normal completion with real data, and no error.
- timeout_err clears only on reset.
- Reset asserted mid-transaction: the next state is IDLE with all outputs at reset values. No rdy pulse is produced for the abandoned transaction.
- Width rules: no arithmetic on data; the counter saturates at its limit and never wraps.

Test Plan:
- I-only read: icache_req=1, icache_addr=0x00000100; memory returns 0xDEADBEEF with mem_rdy in the 2nd busy cycle -> mem_req high cycles N+1..N+2, mem_addr=0x100, mem_wr=0; icache_rdy pulses in N+2 with icache_data=0xDEADBEEF; dcache_rdy stays 0.
- D write: dcache_req=1, wr=1, addr=0x2000, wdata=0x12345678, ws=2 -> mem_* reflect those values for the whole busy state, grant_d=1, dcache_rdy=1 on mem_rdy; back in IDLE the next cycle.
- Round-robin contention (PRIO_MODE=0): both requests held high for 4 transactions with immediate mem_rdy -> grant order I, D, I, D; each transaction is 1 busy cycle plus 1 idle cycle.
- Fixed priority (PRIO_MODE=1): both requests high -> D granted every time while dcache_req stays high; I granted in the first IDLE after dcache_req drops.
- Timeout (TIMEOUT=8): D read, mem_rdy never arrives -> dcache_rdy pulses in the 8th busy cycle with dcache_rdata=0, timeout_err=1 and stays set. Repeat with mem_rdy in the 8th cycle -> normal data and timeout_err stays 0.
- Reset mid-op: assert reset in the 2nd busy cycle of an I read -> next cycle IDLE, mem_req=0, no icache_rdy; a later mem_rdy is ignored.
